// File: rtl/idecode_pkg.sv
`default_nettype none
// ============================================================================
// idecode_pkg : opcode constants, field positions and source-usage decode
// Revision    : 1.0
// ============================================================================
package idecode_pkg;

  localparam int ADDR_W = 32;

  localparam logic [5:0] OP_ALU   = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_LOAD  = 6'h10;
  localparam logic [5:0] OP_STORE = 6'h11;
  localparam logic [5:0] OP_BEQ   = 6'h20;
  localparam logic [5:0] OP_JMP   = 6'h21;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS_MSB  = 20;
  localparam int RS_LSB  = 16;
  localparam int RT_MSB  = 15;
  localparam int RT_LSB  = 11;
  localparam int IMM_MSB = 15;

  // Unknown opcodes behave as NOPs and read no sources.
  function automatic logic uses_rs(input logic [5:0] op);
    case (op)
      OP_ALU, OP_ADDI, OP_LOAD, OP_STORE, OP_BEQ: uses_rs = 1'b1;
      default:                                    uses_rs = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    case (op)
      OP_ALU, OP_STORE, OP_BEQ: uses_rt = 1'b1;
      default:                  uses_rt = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/idecode_hazard.sv
`default_nettype none
// ============================================================================
// idecode_hazard : load-use compare of decode sources against ID/EX dest
// Revision       : 1.0
// ============================================================================
module idecode_hazard
  import idecode_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          v_i,
  input  logic          ex_v,
  input  logic [5:0]    ex_op,
  input  logic [RW-1:0] ex_rd,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic          uses_rs,
  input  logic          uses_rt,
  output logic          haz
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = uses_rs & (rs == ex_rd);
  assign rt_hit = uses_rt & (rt == ex_rd);

  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign haz = v_i & ex_v & (ex_op == OP_LOAD) & (ex_rd != '0) & (rs_hit | rt_hit);

endmodule
`default_nettype wire

// File: rtl/idecode.sv
`default_nettype none
// ============================================================================
// idecode : instruction decode stage with ID/EX register and load-use stall
// Revision: 1.0
// ============================================================================
module idecode
  import idecode_pkg::*;
#(
  parameter int IW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [IW-1:0]     inst_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              v_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [5:0]        op_o,
  output logic [RW-1:0]     rd_o,
  output logic [RW-1:0]     rs_o,
  output logic [RW-1:0]     rt_o,
  output logic [IW-1:0]     imm_o,
  output logic [CNTW-1:0]   stall_cnt_o
);

  logic [5:0]    dec_op;
  logic [RW-1:0] dec_rd;
  logic [RW-1:0] dec_rs;
  logic [RW-1:0] dec_rt;
  logic [IW-1:0] dec_imm;
  logic          dec_uses_rs;
  logic          dec_uses_rt;
  logic          haz;

  assign dec_op      = inst_i[OP_MSB:OP_LSB];
  assign dec_rd      = inst_i[RD_MSB:RD_LSB];
  assign dec_rs      = inst_i[RS_MSB:RS_LSB];
  assign dec_rt      = inst_i[RT_MSB:RT_LSB];
  assign dec_imm     = {{(IW-16){inst_i[IMM_MSB]}}, inst_i[IMM_MSB:0]};
  assign dec_uses_rs = uses_rs(dec_op);
  assign dec_uses_rt = uses_rt(dec_op);

  idecode_hazard #(.RW(RW)) u_hazard (
    .v_i     (v_i),
    .ex_v    (v_o),
    .ex_op   (op_o),
    .ex_rd   (rd_o),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .uses_rs (dec_uses_rs),
    .uses_rt (dec_uses_rt),
    .haz     (haz)
  );

  // A flush discards the dependent instruction, so there is nothing to stall.
  assign stall_o = haz & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_o         <= 1'b0;
      pc_o        <= '0;
      op_o        <= '0;
      rd_o        <= '0;
      rs_o        <= '0;
      rt_o        <= '0;
      imm_o       <= '0;
      stall_cnt_o <= '0;
    end else if (flush_i) begin
      v_o <= 1'b0;
    end else if (haz) begin
      v_o <= 1'b0;
      if (stall_cnt_o != {CNTW{1'b1}}) stall_cnt_o <= stall_cnt_o + 1'b1;
    end else begin
      v_o <= v_i;
      if (v_i) begin
        pc_o  <= pc_i;
        op_o  <= dec_op;
        rd_o  <= dec_rd;
        rs_o  <= dec_rs;
        rt_o  <= dec_rt;
        imm_o <= dec_imm;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_idecode.sv
`default_nettype none
// ============================================================================
// tb_idecode : scoreboard bench for the decode stage (CNTW overridden to 4)
// Revision   : 1.0
// ============================================================================
module tb_idecode;

  localparam int CNTW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_i;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic        flush_i;
  logic        stall_o;
  logic        v_o;
  logic [31:0] pc_o;
  logic [5:0]  op_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs_o;
  logic [4:0]  rt_o;
  logic [31:0] imm_o;
  logic [CNTW-1:0] stall_cnt_o;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_tests = 0;
  int   n_fail  = 0;

  idecode #(.IW(32), .RW(5), .CNTW(CNTW)) dut (
    .clk         (clk),
    .rst         (rst),
    .v_i         (v_i),
    .pc_i        (pc_i),
    .inst_i      (inst_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .v_o         (v_o),
    .pc_o        (pc_o),
    .op_o        (op_o),
    .rd_o        (rd_o),
    .rs_o        (rs_o),
    .rt_o        (rt_o),
    .imm_o       (imm_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Drives one cycle: checks stall_o mid-cycle, predicts the ID/EX state,
  // pushes it, then pops and compares after the clock edge.
  task automatic step(input logic r, input logic v, input logic [31:0] pc,
                      input logic [31:0] inst, input logic fl);
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       haz;
    exp_t       e;
    rst = r; v_i = v; pc_i = pc; inst_i = inst; flush_i = fl;
    op  = inst[31:26];
    rs  = inst[20:16];
    rt  = inst[15:11];
    urs = (op == 6'h00) || (op == 6'h01) || (op == 6'h10) || (op == 6'h11) || (op == 6'h20);
    urt = (op == 6'h00) || (op == 6'h11) || (op == 6'h20);
    haz = v && m.v && (m.op == 6'h10) && (m.rd != 5'd0) &&
          ((urs && rs == m.rd) || (urt && rt == m.rd));
    @(negedge clk);
    check("stall_o", {63'd0, stall_o}, {63'd0, haz && !fl});
    if (r) m = '0;
    else if (fl) m.v = 1'b0;
    else if (haz) begin
      m.v = 1'b0;
      if (m.cnt != {CNTW{1'b1}}) m.cnt = m.cnt + 1'b1;
    end else begin
      m.v = v;
      if (v) begin
        m.pc  = pc;
        m.op  = op;
        m.rd  = inst[25:21];
        m.rs  = rs;
        m.rt  = rt;
        m.imm = {{16{inst[15]}}, inst[15:0]};
      end
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("v_o",   {63'd0, v_o}, {63'd0, e.v});
    check("cnt",   {60'd0, stall_cnt_o}, {60'd0, e.cnt});
    if (e.v) begin
      check("pc_o",  {32'd0, pc_o}, {32'd0, e.pc});
      check("op_o",  {58'd0, op_o}, {58'd0, e.op});
      check("rd_o",  {59'd0, rd_o}, {59'd0, e.rd});
      check("rs_o",  {59'd0, rs_o}, {59'd0, e.rs});
      check("rt_o",  {59'd0, rt_o}, {59'd0, e.rt});
      check("imm_o", {32'd0, imm_o}, {32'd0, e.imm});
    end
  endtask

  logic [31:0] ld4, alu_dep;
  logic [31:0] hold_pc, hold_imm;
  logic [5:0]  ops [7];

  initial begin
    ld4     = 32'h4080_0000;
    alu_dep = mk(6'h00, 5'd7, 5'd4, {5'd6, 11'd0});
    ops     = '{6'h00, 6'h01, 6'h10, 6'h11, 6'h20, 6'h21, 6'h3F};
    m       = '0;

    rst = 1'b1; v_i = 1'b1; pc_i = 32'd9; inst_i = ld4; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_v_o", {63'd0, v_o}, 64'd0);
    check("rst_cnt", {60'd0, stall_cnt_o}, 64'd0);
    check("rst_stall", {63'd0, stall_o}, 64'd0);

    step(1'b0, 1'b1, 32'd3, 32'h0422_0005, 1'b0);
    check("addi_op", {58'd0, op_o}, 64'h01);
    check("addi_rd", {59'd0, rd_o}, 64'd1);
    check("addi_rs", {59'd0, rs_o}, 64'd2);
    check("addi_imm", {32'd0, imm_o}, 64'd5);
    check("addi_pc", {32'd0, pc_o}, 64'd3);

    // Load-use: one stall, one bubble, then the ALU issues.
    step(1'b0, 1'b1, 32'd4, ld4, 1'b0);
    step(1'b0, 1'b1, 32'd5, alu_dep, 1'b0);
    check("lu_bubble", {63'd0, v_o}, 64'd0);
    check("lu_cnt", {60'd0, stall_cnt_o}, 64'd1);
    step(1'b0, 1'b1, 32'd5, alu_dep, 1'b0);
    check("lu_issue", {63'd0, v_o}, 64'd1);

    // Non-hazards
    step(1'b0, 1'b1, 32'd6, mk(6'h10, 5'd0, 5'd1, 16'd0), 1'b0);
    step(1'b0, 1'b1, 32'd7, mk(6'h00, 5'd3, 5'd0, 16'd0), 1'b0);
    step(1'b0, 1'b1, 32'd8, ld4, 1'b0);
    step(1'b0, 1'b1, 32'd9, mk(6'h21, 5'd4, 5'd4, {5'd4, 11'd0}), 1'b0);
    step(1'b0, 1'b1, 32'd10, ld4, 1'b0);
    step(1'b0, 1'b1, 32'd11, mk(6'h01, 5'd5, 5'd2, 16'h2000), 1'b0);
    check("nohaz_cnt", {60'd0, stall_cnt_o}, 64'd1);

    // Flush wins over hazard
    step(1'b0, 1'b1, 32'd12, ld4, 1'b0);
    step(1'b0, 1'b1, 32'd13, alu_dep, 1'b1);
    check("flush_v", {63'd0, v_o}, 64'd0);
    check("flush_cnt", {60'd0, stall_cnt_o}, 64'd1);

    // Sign extension, then invalid cycle holds fields
    step(1'b0, 1'b1, 32'h40, mk(6'h01, 5'd2, 5'd3, 16'h8001), 1'b0);
    check("sext_imm", {32'd0, imm_o}, 64'hFFFF_8001);
    hold_pc = pc_o; hold_imm = imm_o;
    step(1'b0, 1'b0, 32'h44, 32'hDEAD_BEEF, 1'b0);
    check("hold_pc", {32'd0, pc_o}, 64'h40);
    check("hold_imm", {32'd0, imm_o}, 64'hFFFF_8001);

    // Reset mid-stall, stall gone next cycle
    step(1'b0, 1'b1, 32'd20, ld4, 1'b0);
    step(1'b1, 1'b1, 32'd21, alu_dep, 1'b0);
    step(1'b0, 1'b1, 32'd21, alu_dep, 1'b0);
    check("rst_mid_cnt", {60'd0, stall_cnt_o}, 64'd0);

    // Saturation: 2^CNTW+3 hazard pairs
    for (int i = 0; i < (1 << CNTW) + 3; i++) begin
      step(1'b0, 1'b1, 32'd100 + i, ld4, 1'b0);
      step(1'b0, 1'b1, 32'd200 + i, alu_dep, 1'b0);
      step(1'b0, 1'b1, 32'd200 + i, alu_dep, 1'b0);
    end
    check("sat_cnt", {60'd0, stall_cnt_o}, 64'hF);

    // Random mix after a reset
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, ($urandom_range(0, 3) != 0), $urandom,
           {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom)},
           ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/idecode.md
Name: idecode

Overview:
- Instruction Decode stage; sits directly downstream of instruction fetch and upstream of execute.
- Takes the fetched instruction word together with fetch's valid flag and PC.
- Decodes it into fields, registers the result into the ID/EX pipeline register, and detects load-use hazards.
- On a hazard it raises a stall to fetch and inserts a bubble into execute. It also honours a flush from execute on taken branches.

Parameters:
- IW, 32, instruction width in bits.
- RW, 5, register-index width.
- CNTW, 16, stall-cycle counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high
- v_i  in  1  fetch valid; inst_i/pc_i meaningful only when high
- pc_i  in  `ADDR  address of inst_i
- inst_i  in  IW  instruction word from instruction memory, aligned with v_i
- flush_i  in  1  execute resolved a taken branch; discard current decode
- stall_o  out  1  to fetch stall input; combinational
- v_o  out  1  ID/EX valid
- pc_o  out  `ADDR  ID/EX PC
- op_o  out  6  ID/EX opcode
- rd_o, rs_o, rt_o  out  RW each  ID/EX register indices
- imm_o  out  IW  ID/EX immediate, sign-extended
- stall_cnt_o  out  CNTW  saturating count of hazard-stall cycles

Behaviour:
- Encoding:
  - op = inst[31:26], rd = inst[25:21], rs = inst[20:16], rt = inst[15:11], imm = inst[15:0].
  - imm_o = {{16{inst[15]}}, inst[15:0]}.
- Opcodes:
  - OP_ALU 6'h00: uses rs, rt.
  - OP_ADDI 6'h01: uses rs.
  - OP_LOAD 6'h10: uses rs.
  - OP_STORE 6'h11: uses rs, rt.
  - OP_BEQ 6'h20: uses rs, rt.
  - OP_JMP 6'h21: uses none.
  - Any other opcode decodes as NOP: uses none, and is issued with v_o=1 and op_o as received.
- Register 0 is never a hazard source.
- Hazard (combinational): haz = v_i & v_o & (op_o==OP_LOAD) & (rd_o!=0) & ((uses_rs & rs==rd_o) | (uses_rt & rt==rd_o)).
- stall_o = haz & ~flush_i.
- ID/EX register update, every clock, in priority order:
  1. rst: v_o=0, pc_o=0, op_o=0, rd_o=rs_o=rt_o=0, imm_o=0, stall_cnt_o=0.
  2. flush_i: v_o<=0. Fields are don't-care and hold their values. stall_o is 0 this cycle.
  3. haz: v_o<=0 (bubble). Fields hold. stall_cnt_o<=stall_cnt_o+1, saturating at all-ones.
  4. Otherwise: v_o<=v_i. When v_i=1, all fields load from the decode. When v_i=0, fields hold.
- Latency: one cycle from v_i to v_o.
- A stall lasts exactly one cycle per hazard: the bubble clears v_o&LOAD the next cycle, so the re-presented instruction issues.
- Simultaneous flush_i and haz: the flush wins, with no stall and no count increment.
- Reset mid-stall: stall_o drops the cycle after rst, since v_o=0.
- Counter saturates; it does not wrap.

Decomposition:
- OP_* constants, field bit positions and the uses_rs/uses_rt decode belong in the shared include/params.vh, alongside `ADDR.
- One sub-module, idecode_hazard: pure combinational compare of current source indices against the ID/EX destination, producing haz.
- The ID/EX register and counter stay in idecode.

Test Plan:
- Reset: hold rst=1 for 2 cycles with v_i=1 -> v_o=0, stall_o=0, stall_cnt_o=0 on release; first ADDI inst 32'h0422_0005 at pc 3 -> next cycle v_o=1, op_o=01, rd_o=1, rs_o=2, imm_o=5, pc_o=3.
- Load-use:
  - Cycle 1: LOAD rd=4 (32'h4080_0000), then ALU rs=4 rt=6 presented.
  - Required: stall_o=1 for 1 cycle, v_o=0 bubble, stall_cnt_o=1.
  - Re-presented ALU issues next cycle with v_o=1.
- Non-hazards:
  - LOAD rd=0 then ALU rs=0 -> no stall.
  - LOAD rd=4 then JMP -> no stall.
  - LOAD rd=4 then ADDI rt-field=4 (rs=2) -> no stall.
- Flush priority: LOAD rd=4 followed by a dependent ALU with flush_i=1 in the same cycle -> stall_o=0, v_o=0 next, stall_cnt_o unchanged.
- Sign extension and invalid hold:
  - imm 16'h8001 -> imm_o=32'hFFFF_8001.
  - A subsequent cycle with v_i=0 -> v_o=0 and fields hold their values.
- Saturation: force 2^CNTW+3 back-to-back hazard pairs (CNTW=4 bench override) -> stall_cnt_o sticks at 4'hF.
